// File: rtl/sum16_serie.sv
// Serial wide adder: time-multiplexes one 4-bit carry-lookahead adder (sum4), one nibble per cycle.
// Optional subtract mode is enabled by defining SERIE_SUB_EN.

module sum4 (
  output logic [3:0] S,
  output logic       c_out,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       c_in
);

  logic [3:0] g, p;
  logic [4:0] c;

  always_comb begin
    g    = A & B;
    p    = A ^ B;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
           (p[3] & p[2] & p[1] & p[0] & c_in);
    S     = p ^ c[3:0];
    c_out = c[4];
  end

endmodule

module sum16_serie #(
  parameter int unsigned NIB = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [4*NIB-1:0] a,
  input  logic [4*NIB-1:0] b,
  input  logic             cin,
`ifdef SERIE_SUB_EN
  input  logic             sub,
`endif
  output logic [4*NIB-1:0] s,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned W    = 4 * NIB;
  localparam int unsigned IdxW = $clog2(NIB) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    ra, ra_d, rb, rb_d, rs, rs_d, rs_upd, s_d;
  logic [IdxW-1:0] idx, idx_d;
  logic            cr, cr_d, cout_d, done_d, last;
  logic [3:0]      nib_a, nib_b, nib_s;
  logic            nib_c;

  // Select the active operand nibble and merge the fresh sum nibble into the shadow result.
  always_comb begin
    nib_a  = '0;
    nib_b  = '0;
    rs_upd = rs;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (idx == IdxW'(i)) begin
        nib_a             = ra[4*i +: 4];
        nib_b             = rb[4*i +: 4];
        rs_upd[4*i +: 4]  = nib_s;
      end
    end
    last = (idx == IdxW'(NIB - 1));
  end

  sum4 u_sum4 (nib_s, nib_c, nib_a, nib_b, cr);

  always_comb begin
    state_d = state_q;
    ra_d    = ra;
    rb_d    = rb;
    cr_d    = cr;
    idx_d   = idx;
    rs_d    = rs;
    s_d     = s;
    cout_d  = cout;
    done_d  = 1'b0;
    busy    = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          ra_d  = a;
          rb_d  = b;
          cr_d  = cin;
`ifdef SERIE_SUB_EN
          if (sub) begin
            rb_d = ~b;
            cr_d = 1'b1;
          end
`endif
          idx_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        busy = 1'b1;
        rs_d = rs_upd;
        if (last) begin
          // Final carry leaves through cout; cr and idx stay put.
          s_d     = rs_upd;
          cout_d  = nib_c;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          cr_d  = nib_c;
          idx_d = idx + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ra      <= '0;
      rb      <= '0;
      cr      <= 1'b0;
      idx     <= '0;
      rs      <= '0;
      s       <= '0;
      cout    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      ra      <= ra_d;
      rb      <= rb_d;
      cr      <= cr_d;
      idx     <= idx_d;
      rs      <= rs_d;
      s       <= s_d;
      cout    <= cout_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_sum16_serie.sv
// Directed self-checking bench for sum16_serie (NIB=4); sub tests build only with SERIE_SUB_EN.

module tb_sum16_serie;

  logic        clk = 1'b0;
  logic        reset_n, start, cin;
  logic [15:0] a, b, s;
  logic        cout, busy, done;
`ifdef SERIE_SUB_EN
  logic        sub;
`endif
  int          passed = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  sum16_serie #(.NIB(4)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .cin    (cin),
`ifdef SERIE_SUB_EN
    .sub    (sub),
`endif
    .s      (s),
    .cout   (cout),
    .busy   (busy),
    .done   (done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One operation; operands are scrambled after the start edge to prove they were latched.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tc, input logic [15:0] es, input logic ec);
    logic [15:0] prev;
    int          n, busy_n;
    logic        stable;
    prev  = s;
    a     = ta;
    b     = tb_v;
    cin   = tc;
    start = 1'b1;
    tick;
    start = 1'b0;
    a     = ~ta;
    b     = ta ^ tb_v;
    cin   = ~tc;
`ifdef SERIE_SUB_EN
    sub   = ~sub;
`endif
    n      = 0;
    busy_n = 0;
    stable = 1'b1;
    while (!done && n < 20) begin
      if (busy) busy_n++;
      if (s !== prev) stable = 1'b0;
      tick;
      n++;
    end
    chk({tag, " done"}, done, 1);
    chk({tag, " busy_cycles"}, busy_n, 4);
    chk({tag, " s_held"}, stable, 1);
    chk({tag, " s"}, s, es);
    chk({tag, " cout"}, cout, ec);
    tick;
    chk({tag, " done_pulse"}, done, 0);
  endtask

  initial begin
    int          dn;
    logic [15:0] cap_s;
    logic        cap_c;
    reset_n = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    cin     = 1'b0;
`ifdef SERIE_SUB_EN
    sub     = 1'b0;
`endif
    tick;
    tick;
    reset_n = 1'b1;
    chk("reset s", s, 0);
    chk("reset cout", cout, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);

    run_op("cin_only", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    run_op("all_ones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    run_op("zero_ff", 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1);

    // Second start two cycles into a run must be ignored.
    a = 16'h5555; b = 16'hAAAA; cin = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    a = 16'h1234; b = 16'h1111; start = 1'b1;
    tick;
    start = 1'b0;
    dn = 0; cap_s = '0; cap_c = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        dn++;
        cap_s = s;
        cap_c = cout;
      end
      tick;
    end
    chk("ignore done_count", dn, 1);
    chk("ignore s", cap_s, 16'hFFFF);
    chk("ignore cout", cap_c, 0);

    // Reset during the third RUN cycle aborts the operation.
    a = 16'h1234; b = 16'h0001; cin = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort s", s, 0);
    chk("abort cout", cout, 0);
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dn++;
      tick;
    end
    chk("abort no_done", dn, 0);
    run_op("after_abort", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

    // start held high: the DONE cycle accepts the next request.
    a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
    tick;
    a = 16'h0010; b = 16'h0020;
    repeat (3) tick;
    chk("b2b early_done", done, 0);
    tick;
    chk("b2b first_done", done, 1);
    chk("b2b first_s", s, 16'h0003);
    tick;
    start = 1'b0;
    chk("b2b rerun_busy", busy, 1);
    chk("b2b rerun_done", done, 0);
    repeat (3) tick;
    chk("b2b mid_s", s, 16'h0003);
    tick;
    chk("b2b second_done", done, 1);
    chk("b2b second_s", s, 16'h0030);
    tick;

`ifdef SERIE_SUB_EN
    sub = 1'b1;
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
    sub = 1'b1;
    run_op("sub_pos", 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1);
    sub = 1'b0;
    run_op("sub_off", 16'h0007, 16'h0005, 1'b0, 16'h000C, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/sum16_serie.md
# sum16_serie

Multi-cycle 16-bit adder that instantiates the team's combinational 4-bit carry-lookahead adder `sum4` and time-multiplexes it, one nibble per clock. It sits directly around `sum4`: upstream it supplies one nibble of each operand and the carry-in, and downstream it captures `S` and `c_out`. The ripple carry between nibbles is registered. It gives wide additions with one `sum4` instance and a start/busy/done handshake.

## Interface
- `NIB`, default 4: nibbles per operand. Operand width is 4·NIB bits. Legal range is 1..8.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  request; sampled only when not busy.
- `a`  in  4·NIB  operand A; sampled at the start edge.
- `b`  in  4·NIB  operand B; sampled at the start edge.
- `cin`  in  1  carry-in; sampled at the start edge.
- `s`  out  4·NIB  sum; updated only on completion.
- `cout`  out  1  final carry-out; updated only on completion.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Internal `sum4` instance, connected positionally as `(S, c_out, A, B, c_in)`.
- Internal registers:
  - operand latches `ra`, `rb`
  - carry register `cr`
  - nibble index `idx` (width ⌈log2 NIB⌉+1)
  - shadow result `rs`
- FSM states:
  - IDLE: `busy`=0. If `start`=1: latch `a`, `b`; set `cr`←`cin`, `idx`←0; go to RUN.
  - RUN: `busy`=1.
    - Each cycle, drive `sum4` with `ra[4·idx+3:4·idx]`, `rb[4·idx+3:4·idx]` and `cr`.
    - On the edge: write `S` into `rs` nibble `idx`, set `cr`←`c_out`, `idx`←`idx`+1.
    - When `idx`=NIB−1 on that edge: set `s`←final `rs`, `cout`←`c_out`, `done`←1; go to DONE.
  - DONE: `busy`=0 and `done`=1 for this single cycle.
    - If `start`=1: accept exactly as from IDLE and go to RUN.
    - Otherwise go to IDLE.
- `start` while in RUN is ignored. It is neither queued nor does it alter operands.
- `a`, `b` and `cin` may change freely after the start edge without affecting the result.
- Arithmetic: {`cout`,`s`} = `a` + `b` + `cin`, taken modulo 2^(4·NIB+1). Unsigned; no overflow flag.
- `s` and `cout` hold the last result until the next completion. No partial sums are ever visible on `s`.

## Timing
- Reset (`reset_n`=0 at an edge):
  - state←IDLE; `s`←0, `cout`←0, `busy`←0, `done`←0.
  - `rs`, `cr` and `idx` are cleared.
  - Reset has priority over `start`.
- Reset mid-RUN aborts the operation. No `done` is issued, and `s`/`cout` read 0.
- Latency, counting the start edge as E0:
  - `busy`=1 from after E0 through E(NIB−1).
  - `done`=1 and new `s`/`cout` appear after E(NIB), i.e. NIB cycles.
  - With NIB=4: `done` is high in the 5th cycle counted from the start cycle.
- Throughput: back-to-back `start` held high gives one result every NIB+1 cycles. The DONE cycle accepts the next request.
- Final-nibble wrap: `idx` never exceeds NIB−1 while indexing operands.
- The carry out of the final nibble goes to `cout`, not back into `cr`.

## Configuration
- `SERIE_SUB_EN`
  - Defined: adds input port `sub` (1 bit), sampled at the start edge.
    - `sub`=1 latches `rb`←~`b` and `cr`←1, ignoring `cin`.
    - Result is `a`−`b`; `cout`=1 means no borrow.
    - `sub`=0 behaves as plain add.
  - Undefined: no `sub` port; the block adds only.

## Test plan
- Reset, then `a`=0x0000, `b`=0x0000, `cin`=1, start → after 4 cycles: `done` pulse, `s`=0x0001, `cout`=0. Before that, `busy` is high for exactly 4 cycles and `s` stays 0.
- `a`=0xFFFF, `b`=0x0001, `cin`=0 → `s`=0x0000, `cout`=1; the carry propagates through all 4 nibbles.
- `a`=0xFFFF, `b`=0xFFFF, `cin`=1 → `s`=0xFFFF, `cout`=1. Then `a`=0x0000, `b`=0xFFFF, `cin`=1 → `s`=0x0000, `cout`=1.
- `a`=0x5555, `b`=0xAAAA, `cin`=0. Pulse `start` again 2 cycles later with `a`=0x1234, `b`=0x1111 → that second pulse is ignored: `s`=0xFFFF, `cout`=0, and only one `done` is issued.
- `reset_n` low for one edge during the 3rd RUN cycle → no `done`; `s`=0, `cout`=0, `busy`=0. A fresh `a`=0x00FF, `b`=0x0001, `cin`=0 then gives `s`=0x0100.
- (`SERIE_SUB_EN`) `sub`=1, `a`=0x0005, `b`=0x0007 → `s`=0xFFFE, `cout`=0. Then `sub`=1, `a`=0x0007, `b`=0x0005 → `s`=0x0002, `cout`=1.
